wb_port_arbiter: RTL and testbench

- Shares the single register-file write port between two requesters.
  - The in-order pipeline writeback from the MEM/WB stage, with the data already selected by MemtoReg.
  - A long-latency unit (multiplier/divider) that returns results out of band through a valid/ready handshake.
- Long-latency results are buffered in a small FIFO and written back only in cycles where the pipeline is not writing.
- A registered stall request forces bubbles so the FIFO cannot starve.
- Sits between MEM/WB, the long-latency unit, the hazard unit and the register file.

---
 rtl/wb_port_arbiter_pkg.sv | 29 ++
 rtl/wb_port_arbiter_fifo.sv | 90 +++++++++
 rtl/wb_port_arbiter.sv | 137 +++++++++++++
 tb/tb_wb_port_arbiter.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_port_arbiter_pkg.sv
// ============================================================================
// Module      : wb_port_arbiter_pkg
// Description : Shared widths and the buffered writeback entry type used by
//               the register-file write-port arbiter and its result FIFO.
// Contents    : REG_W, XLEN, wb_entry_t (rd + data, 37 bits packed),
//               rd_writes() helper (x0 writes are architectural no-ops).
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package wb_port_arbiter_pkg;

  localparam int REG_W = 5;
  localparam int XLEN  = 32;

  // One pending register-file write: destination in the upper bits, data below.
  typedef struct packed {
    logic [REG_W-1:0] rd;
    logic [XLEN-1:0]  data;
  } wb_entry_t;

  // x0 is hardwired to zero, so a write to it never needs the port.
  function automatic logic rd_writes(input logic [REG_W-1:0] rd);
    return (rd != '0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/wb_port_arbiter_fifo.sv
// ============================================================================
// Module      : wb_result_fifo
// Description : DEPTH-entry synchronous FIFO of pending writeback entries.
//               Push is ignored when full, pop is ignored when empty.
//               No fall-through: an entry pushed into an empty FIFO becomes
//               visible on head_o the following cycle.
// Ports       : clk_i, rst_i (async, active-low)
//               push_i, push_entry_i  - enqueue request and payload
//               pop_i                 - dequeue request
//               head_o                - oldest entry (valid when !empty_o)
//               count_o               - occupancy, 0..DEPTH
//               full_o, empty_o       - occupancy flags
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module wb_result_fifo
  import wb_port_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  wb_entry_t              push_entry_i,
  input  logic                   pop_i,
  output wb_entry_t              head_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wb_entry_t        mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic w_do_push;
  logic w_do_pop;

  assign full_o    = (count_q == CNT_W'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign w_do_push = push_i & ~full_o;
  assign w_do_pop  = pop_i  & ~empty_o;
  assign head_o    = mem_q[rd_ptr_q];
  assign count_o   = count_q;

  // DEPTH is a power of two, so plain pointer increment wraps modulo DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (w_do_push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (w_do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    unique case ({w_do_push, w_do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: reads are gated by the occupancy count.
  always_ff @(posedge clk_i) begin
    if (w_do_push) begin
      mem_q[wr_ptr_q] <= push_entry_i;
    end
  end

endmodule

`default_nettype wire

// File: rtl/wb_port_arbiter.sv
// ============================================================================
// Module      : wb_port_arbiter
// Description : Shares the single register-file write port between the
//               in-order MEM/WB writeback and a long-latency unit. The
//               pipeline always wins; long-latency results are queued and
//               drained into cycles where the pipeline leaves the port free.
//               A registered stall request forces bubbles when the queue has
//               been starved too long or is full.
// Ports       : clk_i, rst_i (async, active-low)
//               wb_valid_i, wb_rd_i, wb_data_i - pipeline writeback
//               mc_valid_i, mc_ready_o, mc_rd_i, mc_data_i - long-latency result
//               rf_we_o, rf_waddr_o, rf_wdata_o - register-file write port
//               stall_o    - drain request to the hazard unit (registered)
//               fifo_cnt_o - queued long-latency results
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int DEPTH    = 2,
  parameter int MAX_WAIT = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   wb_valid_i,
  input  logic [REG_W-1:0]       wb_rd_i,
  input  logic [XLEN-1:0]        wb_data_i,
  input  logic                   mc_valid_i,
  output logic                   mc_ready_o,
  input  logic [REG_W-1:0]       mc_rd_i,
  input  logic [XLEN-1:0]        mc_data_i,
  output logic                   rf_we_o,
  output logic [REG_W-1:0]       rf_waddr_o,
  output logic [XLEN-1:0]        rf_wdata_o,
  output logic                   stall_o,
  output logic [$clog2(DEPTH):0] fifo_cnt_o
);

  localparam int CNT_W  = $clog2(DEPTH) + 1;
  localparam int WAIT_W = 4;

  wb_entry_t        w_head;
  wb_entry_t        w_push_entry;
  logic             w_full;
  logic             w_empty;
  logic             w_pipe_we;
  logic             w_push;
  logic             w_pop;
  logic [CNT_W-1:0] w_cnt_nxt;

  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              stall_q, stall_d;

  // ---------------------------------------------------------------------------
  // Enqueue side. Readiness comes from the registered count only, so a pop in
  // the same cycle never frees a slot for the incoming result.
  // ---------------------------------------------------------------------------
  assign mc_ready_o   = ~w_full;
  // A result destined for x0 completes the handshake but is dropped.
  assign w_push       = mc_valid_i & mc_ready_o & rd_writes(mc_rd_i);
  assign w_push_entry = '{rd: mc_rd_i, data: mc_data_i};

  wb_result_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .push_i       (w_push),
    .push_entry_i (w_push_entry),
    .pop_i        (w_pop),
    .head_o       (w_head),
    .count_o      (fifo_cnt_o),
    .full_o       (w_full),
    .empty_o      (w_empty)
  );

  // ---------------------------------------------------------------------------
  // Write-port priority mux. A pipeline write to x0 is suppressed and leaves
  // the port free for the queue head.
  // ---------------------------------------------------------------------------
  assign w_pipe_we = wb_valid_i & rd_writes(wb_rd_i);

  always_comb begin
    rf_we_o    = 1'b0;
    rf_waddr_o = '0;
    rf_wdata_o = '0;
    w_pop      = 1'b0;
    if (w_pipe_we) begin
      rf_we_o    = 1'b1;
      rf_waddr_o = wb_rd_i;
      rf_wdata_o = wb_data_i;
    end else if (!w_empty) begin
      rf_we_o    = 1'b1;
      rf_waddr_o = w_head.rd;
      rf_wdata_o = w_head.data;
      w_pop      = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Starvation tracking and stall request.
  // ---------------------------------------------------------------------------
  // Occupancy after this edge; push and pop are already qualified so this
  // never under- or overflows.
  assign w_cnt_nxt = fifo_cnt_o + CNT_W'(w_push) - CNT_W'(w_pop);

  always_comb begin
    wait_d = wait_q;
    if (w_pop || w_empty) begin
      wait_d = '0;
    end else if (wait_q < WAIT_W'(MAX_WAIT)) begin
      wait_d = wait_q + WAIT_W'(1);
    end

    // Held until a pop; re-asserted if the post-pop state still qualifies.
    stall_d = (wait_d == WAIT_W'(MAX_WAIT)) ||
              (w_cnt_nxt == CNT_W'(DEPTH)) ||
              (stall_q && !w_pop);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wait_q  <= '0;
      stall_q <= 1'b0;
    end else begin
      wait_q  <= wait_d;
      stall_q <= stall_d;
    end
  end

  assign stall_o = stall_q;

endmodule

`default_nettype wire

// File: tb/tb_wb_port_arbiter.sv
// ============================================================================
// Module      : tb_wb_port_arbiter
// Description : Directed bench for wb_port_arbiter. Each stimulus cycle
//               pushes the register-file write it expects into a queue; a
//               negedge monitor pops and compares on every rf_we_o. Point
//               checks cover ready/count/stall around each scenario.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_wb_port_arbiter;
  import wb_port_arbiter_pkg::*;

  localparam int DEPTH    = 2;
  localparam int MAX_WAIT = 4;
  localparam int CNT_W    = $clog2(DEPTH) + 1;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             wb_valid_i;
  logic [REG_W-1:0] wb_rd_i;
  logic [XLEN-1:0]  wb_data_i;
  logic             mc_valid_i;
  logic             mc_ready_o;
  logic [REG_W-1:0] mc_rd_i;
  logic [XLEN-1:0]  mc_data_i;
  logic             rf_we_o;
  logic [REG_W-1:0] rf_waddr_o;
  logic [XLEN-1:0]  rf_wdata_o;
  logic             stall_o;
  logic [CNT_W-1:0] fifo_cnt_o;

  wb_port_arbiter #(
    .DEPTH    (DEPTH),
    .MAX_WAIT (MAX_WAIT)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .wb_valid_i (wb_valid_i),
    .wb_rd_i    (wb_rd_i),
    .wb_data_i  (wb_data_i),
    .mc_valid_i (mc_valid_i),
    .mc_ready_o (mc_ready_o),
    .mc_rd_i    (mc_rd_i),
    .mc_data_i  (mc_data_i),
    .rf_we_o    (rf_we_o),
    .rf_waddr_o (rf_waddr_o),
    .rf_wdata_o (rf_wdata_o),
    .stall_o    (stall_o),
    .fifo_cnt_o (fifo_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  wb_entry_t exp_q[$];
  wb_entry_t mon_e;
  int        n_tests = 0;
  int        n_fail  = 0;

  // Scoreboard monitor: every port write must match the oldest expectation.
  always @(negedge clk_i) begin
    if (rf_we_o) begin
      n_tests = n_tests + 1;
      if (exp_q.size() == 0) begin
        n_fail = n_fail + 1;
        $display("FAIL rf_write_unexpected: got rd=%0d data=%h, required no write",
                 rf_waddr_o, rf_wdata_o);
      end else begin
        mon_e = exp_q.pop_front();
        if (rf_waddr_o !== mon_e.rd || rf_wdata_o !== mon_e.data) begin
          n_fail = n_fail + 1;
          $display("FAIL rf_write: got rd=%0d data=%h, required rd=%0d data=%h",
                   rf_waddr_o, rf_wdata_o, mon_e.rd, mon_e.data);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests = n_tests + 1;
    if (act !== req) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Apply one cycle of inputs and record the write expected in that cycle.
  task automatic drive(input logic wv, input logic [4:0] wrd, input logic [31:0] wd,
                       input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                       input logic ew, input logic [4:0] erd, input logic [31:0] ed);
    wb_valid_i = wv;
    wb_rd_i    = wrd;
    wb_data_i  = wd;
    mc_valid_i = mv;
    mc_rd_i    = mrd;
    mc_data_i  = md;
    if (ew) exp_q.push_back('{rd: erd, data: ed});
    #2;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // ---------------- reset with a result offered -----------------------
    rst_i = 1'b0;
    drive(0, 0, 0, 1, 5'd9, 32'h99, 0, 0, 0);
    tick(); tick();
    chk("rst_ready", mc_ready_o, 1);
    chk("rst_cnt", fifo_cnt_o, 0);
    chk("rst_we", rf_we_o, 0);
    chk("rst_stall", stall_o, 0);
    chk("rst_waddr", rf_waddr_o, 0);
    chk("rst_wdata", rf_wdata_o, 0);
    rst_i = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("post_rst_cnt", fifo_cnt_o, 0);
    tick();

    // ---------------- idle drain ----------------------------------------
    drive(0, 0, 0, 1, 5'd5, 32'hDEADBEEF, 0, 0, 0);
    chk("drain_no_fallthrough", rf_we_o, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 1, 5'd5, 32'hDEADBEEF);
    chk("drain_cnt1", fifo_cnt_o, 1);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("drain_cnt0", fifo_cnt_o, 0);
    chk("drain_idle_we", rf_we_o, 0);
    tick();

    // x0 pipeline write leaves the port to the queue
    drive(0, 0, 0, 1, 5'd9, 32'h1234, 0, 0, 0);
    tick();
    drive(1, 5'd0, 32'hFFFF, 0, 0, 0, 1, 5'd9, 32'h1234);
    chk("x0_drain_we", rf_we_o, 1);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("x0_drain_cnt", fifo_cnt_o, 0);
    tick();

    // mc result to x0 is accepted but dropped
    drive(0, 0, 0, 1, 5'd0, 32'hBAD, 0, 0, 0);
    chk("mc_x0_ready", mc_ready_o, 1);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("mc_x0_cnt", fifo_cnt_o, 0);
    tick();

    // ---------------- priority ------------------------------------------
    drive(0, 0, 0, 1, 5'd7, 32'h11, 0, 0, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1, 5'd3, 32'h22, 0, 0, 0, 1, 5'd3, 32'h22);
      chk("prio_hold_cnt", fifo_cnt_o, 1);
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 1, 5'd7, 32'h11);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("prio_cnt0", fifo_cnt_o, 0);
    chk("prio_stall", stall_o, 0);
    tick();

    // ---------------- starvation ----------------------------------------
    drive(0, 0, 0, 1, 5'd12, 32'hAAAA, 0, 0, 0);
    tick();
    for (int i = 1; i <= 4; i++) begin
      drive(1, 5'd1, 32'(i), 0, 0, 0, 1, 5'd1, 32'(i));
      chk("starve_stall_low", stall_o, 0);
      tick();
    end
    chk("starve_stall_high", stall_o, 1);
    drive(0, 0, 0, 0, 0, 0, 1, 5'd12, 32'hAAAA);
    chk("starve_stall_held", stall_o, 1);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("starve_stall_cleared", stall_o, 0);
    chk("starve_cnt0", fifo_cnt_o, 0);
    tick();

    // ---------------- full and wrap -------------------------------------
    drive(1, 5'd2, 32'h100, 1, 5'd20, 32'hA0, 1, 5'd2, 32'h100);
    tick();
    drive(1, 5'd2, 32'h101, 1, 5'd21, 32'hA1, 1, 5'd2, 32'h101);
    chk("full_ready_at1", mc_ready_o, 1);
    tick();
    drive(1, 5'd2, 32'h102, 1, 5'd22, 32'hA2, 1, 5'd2, 32'h102);
    chk("full_ready", mc_ready_o, 0);
    chk("full_cnt", fifo_cnt_o, 2);
    chk("full_stall", stall_o, 1);
    tick();
    drive(0, 0, 0, 0, 0, 0, 1, 5'd20, 32'hA0);
    chk("full_third_rejected", fifo_cnt_o, 2);
    tick();
    drive(0, 0, 0, 1, 5'd23, 32'hA3, 1, 5'd21, 32'hA1);
    chk("pushpop_ready", mc_ready_o, 1);
    chk("pushpop_cnt_before", fifo_cnt_o, 1);
    tick();
    drive(0, 0, 0, 0, 0, 0, 1, 5'd23, 32'hA3);
    chk("pushpop_cnt_after", fifo_cnt_o, 1);
    chk("pushpop_stall", stall_o, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("wrap_cnt0", fifo_cnt_o, 0);
    tick();

    // ---------------- async reset mid-operation -------------------------
    drive(1, 5'd4, 32'h40, 1, 5'd25, 32'hB0, 1, 5'd4, 32'h40);
    tick();
    drive(1, 5'd4, 32'h41, 1, 5'd26, 32'hB1, 1, 5'd4, 32'h41);
    tick();
    drive(1, 5'd4, 32'h42, 0, 0, 0, 1, 5'd4, 32'h42);
    chk("arst_pre_cnt", fifo_cnt_o, 2);
    chk("arst_pre_stall", stall_o, 1);
    @(negedge clk_i);
    #1;
    rst_i      = 1'b0;
    wb_valid_i = 1'b0;
    #1;
    chk("arst_we", rf_we_o, 0);
    chk("arst_cnt", fifo_cnt_o, 0);
    chk("arst_stall", stall_o, 0);
    chk("arst_ready", mc_ready_o, 1);
    chk("arst_waddr", rf_waddr_o, 0);
    tick();
    rst_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("arst_no_drain", rf_we_o, 0);
      tick();
    end

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
